// File: rtl/block_map_table.sv
// rtl/block_map_table.sv - block-address translation table feeding the block swap controller
//
// Purpose:
//   Maps SD-card block addresses to SRAM block slots. A lookup that hits answers
//   one cycle after the handshake. A lookup that misses chooses a victim slot and
//   issues a level-held swap request (write-back plus load, or load only). It then
//   waits for the controller's completion pulse before answering.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   lookup_valid_i/ready_o  lookup handshake
//   lookup_addr_i           SD-card block address requested
//   lookup_we_i             requester will write the block (marks slot dirty)
//   resp_valid_o            one-cycle result pulse
//   resp_idx_o/resp_miss_o  slot holding the block / lookup needed a swap
//   flush_i                 invalidate all slots (IDLE only, wins over a lookup)
//   swap_req_o              level-held swap request while in SWAP
//   swap_idx_o              victim slot
//   swap_old_addr_o         victim's current address (write-back target)
//   swap_new_addr_o         address to load
//   swap_load_only_o        victim invalid or clean, so write-back is skipped
//   swap_done_i             completion pulse from the controller
module block_map_table #(
   parameter  int NumSlots  = 4,
   parameter  int AddrWidth = 21,
   localparam int IdxWidth  = $clog2(NumSlots)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 lookup_valid_i,
   output logic                 lookup_ready_o,
   input  logic [AddrWidth-1:0] lookup_addr_i,
   input  logic                 lookup_we_i,
   output logic                 resp_valid_o,
   output logic [IdxWidth-1:0]  resp_idx_o,
   output logic                 resp_miss_o,
   input  logic                 flush_i,
   output logic                 swap_req_o,
   output logic [IdxWidth-1:0]  swap_idx_o,
   output logic [AddrWidth-1:0] swap_old_addr_o,
   output logic [AddrWidth-1:0] swap_new_addr_o,
   output logic                 swap_load_only_o,
   input  logic                 swap_done_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SWAP = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [AddrWidth-1:0]  r_tag [NumSlots];
   logic [NumSlots-1:0]   r_valid;
   logic [NumSlots-1:0]   r_dirty;
   logic [IdxWidth-1:0]   r_rr;
   logic                  r_we;
   logic [IdxWidth-1:0]   r_resp_idx;
   logic                  r_resp_miss;
   logic [IdxWidth-1:0]   r_swap_idx;
   logic [AddrWidth-1:0]  r_swap_old;
   logic [AddrWidth-1:0]  r_swap_new;
   logic                  r_swap_load_only;

   logic                  w_idle;
   logic                  w_accept;
   logic                  w_hit;
   logic [IdxWidth-1:0]   w_hit_idx;
   logic                  w_any_inv;
   logic [IdxWidth-1:0]   w_inv_idx;
   logic [IdxWidth-1:0]   w_victim;
   logic                  w_dup;

   assign w_idle   = (r_state == ST_IDLE);
   // A flush in the same cycle as a lookup takes priority, so the lookup is refused.
   assign w_accept = w_idle & lookup_valid_i & ~flush_i;

   // A tag match only counts on a valid slot.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < NumSlots; i++) begin
         if (r_valid[i] && (r_tag[i] == lookup_addr_i)) begin
            w_hit     = 1'b1;
            w_hit_idx = IdxWidth'(i);
         end
      end
   end

   // Scan from the top down so the lowest-index invalid slot is the one kept.
   always_comb begin
      w_any_inv = 1'b0;
      w_inv_idx = '0;
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_any_inv = 1'b1;
            w_inv_idx = IdxWidth'(i);
         end
      end
   end

   assign w_victim = w_any_inv ? w_inv_idx : r_rr;

   always_comb begin
      w_dup = 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
         for (int j = i + 1; j < NumSlots; j++) begin
            if (r_valid[i] && r_valid[j] && (r_tag[i] == r_tag[j])) begin
               w_dup = 1'b1;
            end
         end
      end
   end

   // Two valid slots holding the same address would make lookups ambiguous.
   a_no_dup_tags: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_dup);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state          <= ST_IDLE;
         for (int i = 0; i < NumSlots; i++) begin
            r_tag[i] <= '0;
         end
         r_valid          <= '0;
         r_dirty          <= '0;
         r_rr             <= '0;
         r_we             <= 1'b0;
         r_resp_idx       <= '0;
         r_resp_miss      <= 1'b0;
         r_swap_idx       <= '0;
         r_swap_old       <= '0;
         r_swap_new       <= '0;
         r_swap_load_only <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (flush_i) begin
                  r_valid <= '0;
                  r_dirty <= '0;
                  r_rr    <= '0;
               end else if (w_accept) begin
                  if (w_hit) begin
                     r_dirty[w_hit_idx] <= r_dirty[w_hit_idx] | lookup_we_i;
                     r_resp_idx         <= w_hit_idx;
                     r_resp_miss        <= 1'b0;
                     r_state            <= ST_RESP;
                  end else begin
                     // Round-robin only advances when every slot is occupied.
                     if (!w_any_inv) begin
                        r_rr <= r_rr + IdxWidth'(1);
                     end
                     r_we             <= lookup_we_i;
                     r_swap_idx       <= w_victim;
                     r_swap_old       <= r_tag[w_victim];
                     r_swap_new       <= lookup_addr_i;
                     r_swap_load_only <= ~r_valid[w_victim] | ~r_dirty[w_victim];
                     r_state          <= ST_SWAP;
                  end
               end
            end
            ST_SWAP: begin
               if (swap_done_i) begin
                  r_tag[r_swap_idx]   <= r_swap_new;
                  r_valid[r_swap_idx] <= 1'b1;
                  r_dirty[r_swap_idx] <= r_we;
                  r_resp_idx          <= r_swap_idx;
                  r_resp_miss         <= 1'b1;
                  r_state             <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Request is decoded from state so an asynchronous reset drops it at once.
   assign lookup_ready_o   = w_idle & ~flush_i;
   assign resp_valid_o     = (r_state == ST_RESP);
   assign resp_idx_o       = r_resp_idx;
   assign resp_miss_o      = r_resp_miss;
   assign swap_req_o       = (r_state == ST_SWAP);
   assign swap_idx_o       = r_swap_idx;
   assign swap_old_addr_o  = r_swap_old;
   assign swap_new_addr_o  = r_swap_new;
   assign swap_load_only_o = r_swap_load_only;

endmodule

// File: doc/block_map_table.md
# block_map_table

Block-address translation table sitting directly upstream of the block swap controller in the user domain. It holds the mapping from SD-card block addresses (21 bit) to SRAM block slots, answers lookups from the requester, and on a miss chooses a victim slot and drives the swap request (write-back of a dirty victim plus load, or load only) into the swap controller, waiting for its completion pulse before responding.

## Interface
- NumSlots, 4: number of SRAM block slots managed; power of two, ≥2; must match the number of SRAM addresses the swap controller indexes.
- AddrWidth, 21: SD-card block address width.
- IdxWidth, $clog2(NumSlots): slot index width (derived, not overridden).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- lookup_valid_i  in  1  lookup request valid.
- lookup_ready_o  out  1  table can accept a lookup.
- lookup_addr_i  in  AddrWidth  SD-card block address requested.
- lookup_we_i  in  1  requester intends to write the block; marks the slot dirty.
- resp_valid_o  out  1  one-cycle pulse: lookup result valid.
- resp_idx_o  out  IdxWidth  slot holding the requested block.
- resp_miss_o  out  1  lookup required a swap.
- flush_i  in  1  invalidate all slots; honoured only in IDLE.
- swap_req_o  out  1  swap request to the controller, level-held.
- swap_idx_o  out  IdxWidth  victim slot index.
- swap_old_addr_o  out  AddrWidth  victim's current SD-card address (write-back target).
- swap_new_addr_o  out  AddrWidth  address to load.
- swap_load_only_o  out  1  victim is invalid or clean; skip write-back.
- swap_done_i  in  1  one-cycle completion pulse from the controller.

## Operation
- Per slot: tag[AddrWidth], valid, dirty. Also a round-robin pointer rr[IdxWidth].
- Reset: all valid and dirty bits 0, tags 0, rr = 0, state IDLE.
- FSM states: IDLE, SWAP, RESP.
- IDLE:
  - lookup_ready_o = 1.
  - On a handshake (valid & ready), compare lookup_addr_i against all valid tags.
  - Hit: set dirty[i] |= lookup_we_i, register resp_idx = i, resp_miss = 0, go to RESP.
  - Miss: choose the victim, latch the swap outputs, go to SWAP.
  - A tag match on an invalid slot is not a hit.
  - By construction at most one valid slot matches. Duplicate valid tags are illegal and must be flagged by an assertion.
- Victim selection:
  - If any slot is invalid, pick the lowest-index invalid slot; rr is unchanged.
  - Otherwise pick rr, and rr becomes rr+1, wrapping at NumSlots-1 → 0.
- Swap output latching:
  - swap_idx_o = victim index.
  - swap_old_addr_o = tag[victim].
  - swap_new_addr_o = lookup_addr_i.
  - swap_load_only_o = ~valid[victim] | ~dirty[victim].
- SWAP:
  - swap_req_o = 1 and all swap_* outputs are held stable.
  - On swap_done_i: tag[victim] = new address, valid = 1, dirty = lookup_we (latched); register resp_idx = victim, resp_miss = 1; go to RESP.
  - swap_req_o drops in the cycle after swap_done_i. The controller samples the request only when idle, so a held level is never re-taken.
- RESP: resp_valid_o = 1 for exactly one cycle, then return to IDLE.
- flush_i in IDLE clears all valid and dirty bits and resets rr to 0. If flush_i and lookup_valid_i are high in the same cycle, the flush wins and lookup_ready_o is 0 that cycle. flush_i outside IDLE is ignored.
- swap_done_i outside SWAP is ignored.
- Reset mid-swap returns everything to the reset state immediately. swap_req_o goes to 0 asynchronously.

## Timing
- All outputs are registered or decoded from the state. Reset values: every output 0, except lookup_ready_o = 1.
- Hit: handshake in cycle N → resp_valid_o in cycle N+1. Next lookup can be accepted in N+2.
- Miss: handshake in cycle N → swap_req_o rises in N+1. swap_done_i arrives in cycle M → resp_valid_o and swap_req_o = 0 in M+1. Next lookup can be accepted in M+2.
- The table, dirty bits and rr are updated on the handshake edge for hits and on the swap_done_i edge for misses. A lookup in the next accepted cycle observes the updated values.
- lookup_ready_o = 0 in SWAP and RESP.

## Test plan
- Reset, then lookup 0x00010 with we = 0: swap_req_o = 1, idx 0, load_only = 1. Pulse done after 20 cycles → resp idx 0, miss = 1, swap_req_o low in the same cycle as resp.
- Repeat the lookup of 0x00010 with we = 1 → resp one cycle after the handshake, miss = 0, idx 0, no swap_req_o. Slot 0 becomes dirty.
- Fill slots 1–3 with 0x00011–0x00013, then look up 0x00020 → victim idx 0 (rr), old_addr 0x00010, new_addr 0x00020, load_only = 0. rr becomes 1.
- Look up 0x00030 next → victim idx 1 with load_only = 1 (clean). Continue misses to wrap rr 3 → 0.
- flush_i together with lookup_valid_i in IDLE → ready = 0 that cycle. The next lookup of 0x00011 misses with idx 0 and load_only = 1.
- Assert rst_ni low during SWAP → swap_req_o drops immediately. A late swap_done_i after reset produces no resp_valid_o. The next lookup misses into idx 0.
